// File: rtl/sa_job_arbiter_if.sv
// Handshake bundle between the job arbiter, its requesters and the systolic array.
interface sa_job_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            sa_start;
  logic            sa_done;
  logic            busy;
  logic            job_done;
  logic [2:0]      job_id;
  logic            err;
  logic [15:0]     job_cnt;

  modport master (
    input  req, sa_done,
    output gnt, sa_start, busy, job_done, job_id, err, job_cnt
  );

  modport slave (
    output req, sa_done,
    input  gnt, sa_start, busy, job_done, job_id, err, job_cnt
  );
endinterface

// File: rtl/sa_job_arbiter.sv
// Round-robin arbiter granting one shared systolic array to NREQ requesters.
// Optional WAIT timeout is enabled by defining SA_ARB_TIMEOUT_EN.
module sa_job_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  sa_job_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StFinish} state_e;

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic            sa_start_q;
  logic            busy_q;
  logic            job_done_q;
  logic            err_q;
  logic [2:0]      job_id_q;
  logic [2:0]      rr_ptr_q;
  logic [15:0]     job_cnt_q;

  logic            win_found;
  logic [2:0]      win_idx;
  int              k;
  logic            timeout_hit;

  // First pending requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      k = (int'(rr_ptr_q) + i) % int'(NREQ);
      if (!win_found && bus.req[k]) begin
        win_found = 1'b1;
        win_idx   = 3'(k);
      end
    end
  end

`ifdef SA_ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT);
  logic [7:0] tmo_cnt_q;

  // tmo_cnt_q holds the number of WAIT cycles already completed.
  assign timeout_hit = (state_q == StWait) && ((tmo_cnt_q + 8'd1) == TmoLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StWait && !bus.sa_done && !timeout_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      sa_start_q <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      err_q      <= 1'b0;
      job_id_q   <= '0;
      rr_ptr_q   <= '0;
      job_cnt_q  <= '0;
    end else begin
      sa_start_q <= 1'b0;
      job_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q    <= StStart;
            gnt_q      <= NREQ'(1) << win_idx;
            job_id_q   <= win_idx;
            sa_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StWait;
        end
        StWait: begin
          if (bus.sa_done || timeout_hit) begin
            state_q    <= StFinish;
            job_done_q <= 1'b1;
            err_q      <= !bus.sa_done;
          end
        end
        StFinish: begin
          state_q  <= StIdle;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          err_q    <= 1'b0;
          rr_ptr_q <= (job_id_q == 3'(NREQ - 1)) ? 3'd0 : job_id_q + 3'd1;
          if (job_cnt_q != 16'hFFFF) begin
            job_cnt_q <= job_cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sa_start = sa_start_q;
  assign bus.busy     = busy_q;
  assign bus.job_done = job_done_q;
  assign bus.err      = err_q;
  assign bus.job_id   = job_id_q;
  assign bus.job_cnt  = job_cnt_q;

endmodule
